posit_encode_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial posit encoder (sign/regime/es/mantissa bit-serial packer, 32-bit posit, es=3) between N_REQ requesters.
- Accepts decoded fields from requesters, drives the encoder's start/received handshake, captures the packed posit and returns it to the owning requester.
- Adds a completion watchdog; a hung encoder returns NaR and sets a sticky error.
- Sits between the arithmetic units and the single encoder instance.

---
 rtl/posit_encode_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_posit_encode_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_encode_arbiter.sv
// Round-robin front end for one shared bit-serial posit encoder (32-bit, es=3).
// Grants one requester at a time and holds its decoded fields steady for the encoder.
// Captures the packed result, or NaR if a completion watchdog expires.
// Returns the result to the owning requester on a valid/ready handshake.
module posit_encode_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_sign,
    input  logic [6*N_REQ-1:0]    req_k,
    input  logic [3*N_REQ-1:0]    req_exp,
    input  logic [32*N_REQ-1:0]   req_mant,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_posit,
    output logic                  rsp_err,
    output logic                  enc_start,
    output logic                  enc_received,
    output logic                  enc_sign,
    output logic [5:0]            enc_k,
    output logic [2:0]            enc_exp,
    output logic [31:0]           enc_mant,
    input  logic [31:0]           enc_result,
    input  logic                  enc_done,
    output logic                  err_sticky
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [31:0]      NAR = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StDrain,
        StResp
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [WD_W-1:0]   wdog_q;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic [N_REQ-1:0]  owner_onehot;

    logic [5:0]        k_arr    [N_REQ];
    logic [2:0]        exp_arr  [N_REQ];
    logic [31:0]       mant_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign k_arr[i]    = req_k[6*i +: 6];
        assign exp_arr[i]  = req_exp[3*i +: 3];
        assign mant_arr[i] = req_mant[32*i +: 32];
    end

    // Pick the first valid requester at or after the round-robin pointer
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [IDX_W-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr_q} + SUM_W'(off);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Accept pulse is combinational; transfer completes on the same clock edge
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && !enc_done && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign ptr_next     = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
    assign owner_onehot = N_REQ'(1) << owner_q;

    // Sequencer: grant, start pulse, wait/watchdog, received pulse, drain, respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            owner_q      <= '0;
            wdog_q       <= '0;
            enc_start    <= 1'b0;
            enc_received <= 1'b0;
            enc_sign     <= 1'b0;
            enc_k        <= '0;
            enc_exp      <= '0;
            enc_mant     <= '0;
            rsp_valid    <= '0;
            rsp_posit    <= '0;
            rsp_err      <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            enc_start    <= 1'b0;
            enc_received <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A done still high from the last op must clear before a new start
                    if (!enc_done && sel_found) begin
                        enc_sign  <= req_sign[sel_idx];
                        enc_k     <= k_arr[sel_idx];
                        enc_exp   <= exp_arr[sel_idx];
                        enc_mant  <= mant_arr[sel_idx];
                        owner_q   <= sel_idx;
                        ptr_q     <= ptr_next;
                        enc_start <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    wdog_q  <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (enc_done) begin
                        rsp_posit    <= enc_result;
                        rsp_err      <= 1'b0;
                        enc_received <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= StDrain;
                    end else if (wdog_q == WD_LAST) begin
                        // Hung encoder: answer NaR without handshaking it
                        rsp_posit  <= NAR;
                        rsp_err    <= 1'b1;
                        err_sticky <= 1'b1;
                        rsp_valid  <= owner_onehot;
                        state_q    <= StResp;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!enc_done) begin
                        rsp_valid <= owner_onehot;
                        state_q   <= StResp;
                    end else if (wdog_q == WD_LAST) begin
                        // Result already captured; only flag that done never dropped
                        err_sticky <= 1'b1;
                        rsp_valid  <= owner_onehot;
                        state_q    <= StResp;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid <= '0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_posit_encode_arbiter.sv
// Bench for posit_encode_arbiter with a behavioural serial-encoder stub.
// Expected responses are queued at issue time and checked by a negedge monitor.
module tb_posit_encode_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 8;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     req_sign;
    logic [6*N_REQ-1:0]   req_k;
    logic [3*N_REQ-1:0]   req_exp;
    logic [32*N_REQ-1:0]  req_mant;
    logic [N_REQ-1:0]     rsp_valid;
    logic [N_REQ-1:0]     rsp_ready;
    logic [31:0]          rsp_posit;
    logic                 rsp_err;
    logic                 enc_start;
    logic                 enc_received;
    logic                 enc_sign;
    logic [5:0]           enc_k;
    logic [2:0]           enc_exp;
    logic [31:0]          enc_mant;
    logic [31:0]          enc_result;
    logic                 enc_done;
    logic                 err_sticky;

    posit_encode_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sign     (req_sign),
        .req_k        (req_k),
        .req_exp      (req_exp),
        .req_mant     (req_mant),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_posit    (rsp_posit),
        .rsp_err      (rsp_err),
        .enc_start    (enc_start),
        .enc_received (enc_received),
        .enc_sign     (enc_sign),
        .enc_k        (enc_k),
        .enc_exp      (enc_exp),
        .enc_mant     (enc_mant),
        .enc_result   (enc_result),
        .enc_done     (enc_done),
        .err_sticky   (err_sticky)
    );

    typedef struct {
        int          idx;
        logic [31:0] posit;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   starts   = 0;
    int   recvs    = 0;
    int   grants   = 0;

    logic        hang;
    int          st;
    int          cnt;
    logic [41:0] cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=bound expired required=event seen", name);
    endtask

    // Reference packer: sign, regime run, 3 exponent bits, fraction; negative = two's complement
    function automatic logic [31:0] pack(input logic s, input logic [5:0] k,
                                         input logic [2:0] e, input logic [31:0] m);
        logic [63:0] b;
        logic [31:0] mag;
        int          pos;
        int          kk;
        b   = '0;
        pos = 62;
        kk  = int'($signed(k));
        if (kk >= 0) begin
            for (int i = 0; i <= kk; i++) begin
                if (pos >= 0) b[pos] = 1'b1;
                pos--;
            end
            pos--;
        end else begin
            for (int i = 0; i < -kk; i++) pos--;
            if (pos >= 0) b[pos] = 1'b1;
            pos--;
        end
        for (int i = 2; i >= 0; i--) begin
            if (pos >= 0) b[pos] = e[i];
            pos--;
        end
        for (int i = 31; i >= 0; i--) begin
            if (pos >= 0) b[pos] = m[i];
            pos--;
        end
        mag = b[63:32];
        return s ? (~mag + 32'd1) : mag;
    endfunction

    // Encoder stub: busy for LAT cycles, holds done until received, clears done one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= 0;
            cnt        <= 0;
            cap        <= '0;
            enc_done   <= 1'b0;
            enc_result <= '0;
        end else begin
            case (st)
                0: if (enc_start) begin
                    st  <= 1;
                    cnt <= 0;
                    cap <= {enc_sign, enc_k, enc_exp, enc_mant};
                end
                1: if (!hang) begin
                    if (cnt == LAT - 1) begin
                        enc_done   <= 1'b1;
                        enc_result <= pack(enc_sign, enc_k, enc_exp, enc_mant);
                        st         <= 2;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                2: if (enc_received) st <= 3;
                default: begin
                    enc_done <= 1'b0;
                    st       <= 0;
                end
            endcase
        end
    end

    // Monitor: pulse counting, operand stability, scoreboard pop on each response handshake
    initial begin
        exp_t             e;
        logic [N_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (enc_start) starts++;
                if (enc_received) begin
                    recvs++;
                    chk("received_only_when_done", 64'(st), 64'd2);
                end
                if (st == 1 && !hang) begin
                    chk("operands_stable", {21'd0, enc_start, enc_sign, enc_k, enc_exp, enc_mant},
                        {22'd0, cap});
                end
                if (req_ready != '0) begin
                    grants++;
                    chk("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: actual=rsp_valid %b required=none", rsp_valid);
                    end else begin
                        e  = sb.pop_front();
                        oh = N_REQ'(1) << e.idx;
                        chk("rsp_owner", 64'(rsp_valid), 64'(oh));
                        chk("rsp_posit", 64'(rsp_posit), 64'(e.posit));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic set_op(input int i, input logic s, input logic [5:0] k,
                          input logic [2:0] e, input logic [31:0] m);
        req_sign[i]         = s;
        req_k[6*i +: 6]     = k;
        req_exp[3*i +: 3]   = e;
        req_mant[32*i +: 32] = m;
    endtask

    task automatic expect_rsp(input int i, input logic [31:0] p, input logic err);
        exp_t t;
        t.idx   = i;
        t.posit = p;
        t.err   = err;
        sb.push_back(t);
    endtask

    // Raise req_valid[i], wait for its accept, drop it just after the transfer edge
    task automatic request(input int i);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 500);
        if (!req_ready[i]) fail_now($sformatf("grant_timeout_%0d", i));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("response_timeout");
            sb.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_posit_err"}, {31'd0, rsp_err, rsp_posit}, 64'd0);
        chk({tag, "_enc_ctrl"}, {62'd0, enc_start, enc_received}, 64'd0);
        chk({tag, "_enc_operands"}, {22'd0, enc_sign, enc_k, enc_exp, enc_mant}, 64'd0);
        chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s0;
        int g0;
        int r0;
        int n;
        int gcnt;

        rst_n     = 1'b0;
        hang      = 1'b0;
        req_valid = '0;
        req_sign  = '0;
        req_k     = '0;
        req_exp   = '0;
        req_mant  = '0;
        rsp_ready = '1;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request: zero fields give 1.0
        s0 = starts;
        set_op(0, 1'b0, 6'd0, 3'd0, 32'd0);
        expect_rsp(0, 32'h4000_0000, 1'b0);
        request(0);
        wait_empty();
        chk("single_start_count", 64'(starts - s0), 64'd1);

        // Regime / exponent / fraction placement, negative regime, sign
        set_op(1, 1'b0, 6'd1, 3'b101, 32'h8000_0000);
        expect_rsp(1, 32'h6B00_0000, 1'b0);
        request(1);
        wait_empty();
        set_op(2, 1'b0, 6'h3F, 3'd0, 32'd0);
        expect_rsp(2, 32'h2000_0000, 1'b0);
        request(2);
        wait_empty();
        set_op(3, 1'b1, 6'd0, 3'd0, 32'd0);
        expect_rsp(3, 32'hC000_0000, 1'b0);
        request(3);
        wait_empty();

        // Round robin with all requesters held valid; pointer is back at 0
        set_op(0, 1'b0, 6'd0, 3'd0, 32'd0);
        set_op(3, 1'b0, 6'd2, 3'd0, 32'd0);
        expect_rsp(0, 32'h4000_0000, 1'b0);
        expect_rsp(1, 32'h6B00_0000, 1'b0);
        expect_rsp(2, 32'h2000_0000, 1'b0);
        expect_rsp(3, 32'h7000_0000, 1'b0);
        expect_rsp(0, 32'h4000_0000, 1'b0);
        s0   = starts;
        g0   = grants;
        gcnt = 0;
        n    = 0;
        req_valid = '1;
        while (gcnt < 5 && n < 3000) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) gcnt++;
        end
        if (gcnt < 5) fail_now("rr_grants");
        @(posedge clk);
        #1 req_valid = '0;
        wait_empty();
        chk("rr_start_count", 64'(starts - s0), 64'd5);
        chk("rr_grant_count", 64'(grants - g0), 64'd5);

        // Back-pressure on requester 0 while requester 1 waits
        rsp_ready[0] = 1'b0;
        set_op(0, 1'b0, 6'd0, 3'b001, 32'd0);
        expect_rsp(0, 32'h4400_0000, 1'b0);
        request(0);
        n = 0;
        while (rsp_valid == '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid == '0) fail_now("bp_rsp_valid");
        @(posedge clk);
        #1;
        expect_rsp(1, 32'h6B00_0000, 1'b0);
        req_valid[1] = 1'b1;
        s0 = starts;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid_held", 64'(rsp_valid), 64'b0001);
            chk("bp_rsp_posit_held", 64'(rsp_posit), 64'h4400_0000);
            chk("bp_no_grant", {63'd0, enc_start}, 64'(req_ready));
        end
        chk("bp_no_start", 64'(starts - s0), 64'd0);
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        request(1);
        wait_empty();
        chk("bp_start_after_release", 64'(starts - s0), 64'd1);

        // Watchdog: encoder never completes
        hang = 1'b1;
        r0   = recvs;
        set_op(2, 1'b0, 6'd0, 3'd0, 32'd0);
        expect_rsp(2, 32'h8000_0000, 1'b1);
        request(2);
        n = 0;
        while (rsp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(TIMEOUT + 2));
        wait_empty();
        chk("timeout_no_received", 64'(recvs - r0), 64'd0);
        chk("timeout_err_sticky", 64'(err_sticky), 64'd1);

        // Reset clears the sticky error and the hung encoder
        rst_n = 1'b0;
        hang  = 1'b0;
        #1 chk("sticky_cleared_by_reset", 64'(err_sticky), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT_DONE, then a normal operation
        set_op(1, 1'b0, 6'd1, 3'b101, 32'h8000_0000);
        request(1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midop");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_rsp(1, 32'h6B00_0000, 1'b0);
        request(1);
        wait_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
